// File: rtl/keypad_pkg.sv
// Shared constants and frame classification for the keypad scanner.
// Pure definitions: no latency, no backpressure.
package keypad_pkg;

  localparam int FRAME_ROWS = 4;
  localparam int FRAME_COLS = 4;
  localparam int FRAME_BITS = FRAME_ROWS * FRAME_COLS;

  // Entry r is the active-low drive pattern for row r.
  localparam logic [3:0][3:0] ROW_PATTERN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESSED = 1'b1;

  // Bit 4 set marks "no single key"; a single key is {1'b0, code}.
  typedef logic [4:0] key_class_t;
  localparam key_class_t KEY_NONE  = 5'h10;
  localparam key_class_t KEY_MULTI = 5'h11;

  function automatic key_class_t classify(input logic [FRAME_BITS-1:0] f);
    int         n;
    key_class_t c;
    n = 0;
    c = KEY_NONE;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (f[i]) begin
        n++;
        c = {1'b0, 4'(i)};
      end
    end
    if (n == 0)
      return KEY_NONE;
    else if (n == 1)
      return c;
    else
      return KEY_MULTI;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus debounced key outputs; master is the scanner side.
// Plain wires: no latency, no backpressure.
interface keypad_scanner_if;
  logic [3:0] keypadCol;
  logic [3:0] keypadRow;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input keypadCol, output keypadRow, output key_code,
                  output key_valid, output key_held);
  modport slave  (output keypadCol, input keypadRow, input key_code,
                  input key_valid, input key_held);
endinterface

// File: rtl/keypad_row_driver.sv
// Row scan and frame capture; frame/frame_done describe the frame completed on this edge.
// One row per tick, frame every 4 ticks; no backpressure.
module keypad_row_driver
  import keypad_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            keypadCol,
  output logic [3:0]            keypadRow,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_done
);

  logic [1:0]            row_idx;
  logic [FRAME_BITS-1:0] frame_q;

  assign keypadRow  = ROW_PATTERN[row_idx];
  assign frame_done = (row_idx == 2'd3);

  // Merge the row being sampled now so the consumer sees the full frame on the row-3 edge.
  always_comb begin
    frame = frame_q;
    frame[{row_idx, 2'b00} +: 4] = ~keypadCol;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx <= 2'd0;
      frame_q <= '0;
    end else begin
      row_idx <= row_idx + 2'd1;
      frame_q <= frame;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan, frame debounce and press/release FSM with registered outputs.
// key_valid follows the DEBOUNCE_SCANS-th matching frame edge; no backpressure.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam logic [3:0] STABLE_CNT = 4'(DEBOUNCE_SCANS);

  logic [FRAME_BITS-1:0] frame;
  logic                  frame_done;
  logic [3:0]            row_drive;

  key_class_t cls;
  key_class_t prev_cls;
  logic [3:0] stable_cnt;
  logic [3:0] cnt_next;
  logic       stable;
  logic [0:0] state;

  logic [3:0] key_code_q;
  logic       key_valid_q;
  logic       key_held_q;

  keypad_row_driver u_row_driver (
    .clk        (clk),
    .rst        (rst),
    .keypadCol  (kp.keypadCol),
    .keypadRow  (row_drive),
    .frame      (frame),
    .frame_done (frame_done)
  );

  // Ghosted frames debounce as empty so they can never yield a code.
  always_comb begin
    cls = classify(frame);
    if (cls == KEY_MULTI)
      cls = KEY_NONE;
    if (cls != prev_cls)
      cnt_next = 4'd1;
    else if (stable_cnt == STABLE_CNT)
      cnt_next = stable_cnt;
    else
      cnt_next = stable_cnt + 4'd1;
    stable = (cnt_next == STABLE_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cls    <= KEY_NONE;
      stable_cnt  <= 4'd0;
      state       <= ST_IDLE;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_done) begin
        prev_cls   <= cls;
        stable_cnt <= cnt_next;
        if (stable) begin
          case (state)
            ST_IDLE: begin
              if (!cls[4]) begin
                state       <= ST_PRESSED;
                key_code_q  <= cls[3:0];
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end
            end
            default: begin
              // A different stable key is ignored until everything is released.
              if (cls[4]) begin
                state      <= ST_IDLE;
                key_held_q <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

  assign kp.keypadRow = row_drive;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner with a frame-level reference model.
// Expected key_valid events are queued per frame and popped by a monitor.
module tb_keypad_scanner;

  localparam int DEB = 3;

  logic clk;
  logic rst;
  logic [15:0] mask;

  keypad_scanner_if kp();

  keypad_scanner #(.DEBOUNCE_SCANS(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  logic [3:0] row_pat [4];
  initial begin
    row_pat[0] = 4'b1110;
    row_pat[1] = 4'b1101;
    row_pat[2] = 4'b1011;
    row_pat[3] = 4'b0111;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a closed switch pulls its column low while its row is driven.
  always_comb begin
    kp.keypadCol = 4'hF;
    for (int r = 0; r < 4; r++)
      if (kp.keypadRow == row_pat[r])
        kp.keypadCol = ~mask[r*4 +: 4];
  end

  int checks;
  int errors;
  int exp_q[$];
  int hist[$];
  bit m_held;
  int m_code;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Reference: a key is accepted when the last DEB whole frames agree.
  task automatic model_frame(input logic [15:0] m);
    int  cls;
    bit  stable;
    cls = -1;
    if ($countones(m) == 1)
      for (int i = 0; i < 16; i++)
        if (m[i]) cls = i;
    hist.push_back(cls);
    stable = (hist.size() >= DEB);
    if (stable)
      for (int k = 1; k <= DEB; k++)
        if (hist[hist.size()-k] != cls) stable = 0;
    if (stable) begin
      if (!m_held && cls >= 0) begin
        m_held = 1;
        m_code = cls;
        exp_q.push_back(cls);
      end else if (m_held && cls < 0) begin
        m_held = 0;
      end
    end
  endtask

  task automatic run_frame(input logic [15:0] m);
    mask = m;
    for (int i = 0; i < 4; i++) begin
      check("row_drive", kp.keypadRow, row_pat[i]);
      @(posedge clk);
      #1;
    end
    model_frame(m);
    check("key_held", kp.key_held, m_held);
    check("key_code", kp.key_code, m_code);
  endtask

  task automatic run_frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_row", kp.keypadRow, 4'b1110);
    check("rst_valid", kp.key_valid, 0);
    check("rst_held", kp.key_held, 0);
    check("rst_code", kp.key_code, 0);
    hist.delete();
    m_held = 0;
    m_code = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    int e;
    if (!rst && kp.key_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid act_code=%0d exp=no_pulse", kp.key_code);
      end else begin
        e = exp_q.pop_front();
        if (kp.key_code != 4'(e)) begin
          errors++;
          $display("FAIL valid_code act=%0d exp=%0d", kp.key_code, e);
        end
      end
    end
  end

  function automatic logic [15:0] bit_of(input int c);
    logic [15:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  initial begin
    int kind, len, c1, c2;
    logic [15:0] m;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    mask = '0;
    #2;

    // Idle scanning
    do_reset();
    run_frames(16'h0000, 4);

    // Key 9 held from reset, then released
    mask = bit_of(9);
    do_reset();
    run_frames(bit_of(9), 4);
    run_frames(16'h0000, 4);

    // Bouncing key 3
    run_frames(bit_of(3), 2);
    run_frames(16'h0000, 1);
    run_frames(bit_of(3), 3);
    run_frames(16'h0000, 3);

    // Ghosting guard: 5 and 10 together, then only 5
    run_frames(bit_of(5) | bit_of(10), 5);
    run_frames(bit_of(5), 3);
    run_frames(16'h0000, 3);

    // No re-trigger while pressed
    run_frames(bit_of(7), 3);
    run_frames(bit_of(12), 5);
    run_frames(16'h0000, 3);
    run_frames(bit_of(12), 3);
    run_frames(16'h0000, 3);

    // Reset mid-frame during debounce of key 4
    run_frames(bit_of(4), 2);
    mask = bit_of(4);
    repeat (2) @(posedge clk);
    #3;
    do_reset();
    run_frames(bit_of(4), 3);
    run_frames(16'h0000, 3);

    // Randomized runs
    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      c1   = $urandom_range(0, 15);
      c2   = (c1 + $urandom_range(1, 15)) % 16;
      case (kind)
        0:       m = 16'h0000;
        3:       m = bit_of(c1) | bit_of(c2);
        default: m = bit_of(c1);
      endcase
      run_frames(m, len);
    end
    run_frames(16'h0000, 3);

    repeat (2) @(posedge clk);
    #1;
    check("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
